// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
// Contents: datapath/register-index widths, the packed EX-stage control
// word, the all-zero bubble constant, and an index-match helper used by
// both the forwarding muxes and the load-use detector.
package pipe_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          valid;
    logic          wreg;
    logic          m2reg;
    logic          wmem;
    logic [3:0]    aluc;
    logic [RW-1:0] rn;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;

  // Register $0 is hard-wired to zero, so a match on index 0 never counts.
  function automatic logic idx_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a == b) && (a != {RW{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding selector for one source operand.
// Ports:
//   i_idx               source register index
//   i_rf                register-file read value
//   i_ex_fwd            EX stage holds a forwardable (non-load) writer
//   i_ex_rn, i_ex_s     EX destination and live ALU result
//   i_m_wreg, i_m_m2reg MEM stage write enable / load select
//   i_m_rn              MEM destination
//   i_m_alu, i_m_mo     MEM ALU result and load data
//   o_val               forwarded operand
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_idx,
  input  logic [DW-1:0] i_rf,
  input  logic          i_ex_fwd,
  input  logic [RW-1:0] i_ex_rn,
  input  logic [DW-1:0] i_ex_s,
  input  logic          i_m_wreg,
  input  logic          i_m_m2reg,
  input  logic [RW-1:0] i_m_rn,
  input  logic [DW-1:0] i_m_alu,
  input  logic [DW-1:0] i_m_mo,
  output logic [DW-1:0] o_val
);
  import pipe_pkg::*;

  // Youngest producer wins: EX over MEM over the register file.
  always_comb begin
    o_val = i_rf;
    if (i_ex_fwd && idx_match(i_idx, i_ex_rn)) begin
      o_val = i_ex_s;
    end else if (i_m_wreg && idx_match(i_idx, i_m_rn)) begin
      if (i_m_m2reg) begin
        o_val = i_m_mo;
      end else begin
        o_val = i_m_alu;
      end
    end else begin
      o_val = i_rf;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   d_*                     decoded instruction and controls from ID
//   d_flush                 squash the decode-slot instruction
//   ex_hold                 freeze the EX register
//   ex_alu_s                live ALU result of the instruction in EX
//   m_*                     MEM-stage forwarding taps
//   e_*                     registered EX-stage operands and controls
//   stall_o                 combinational load-use stall request
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [DW-1:0] d_qa,
  input  logic [DW-1:0] d_qb,
  input  logic [DW-1:0] d_imm,
  input  logic [4:0]    d_sa,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic          d_rs_used,
  input  logic          d_rt_used,
  input  logic [RW-1:0] d_rn,
  input  logic [3:0]    d_aluc,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic          d_flush,
  input  logic          ex_hold,
  input  logic [DW-1:0] ex_alu_s,
  input  logic [RW-1:0] m_rn,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [DW-1:0] m_alu,
  input  logic [DW-1:0] m_mo,
  output logic          e_valid,
  output logic [DW-1:0] e_a,
  output logic [DW-1:0] e_b,
  output logic [3:0]    e_aluc,
  output logic [DW-1:0] e_store,
  output logic [RW-1:0] e_rn,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          stall_o
);
  import pipe_pkg::*;

  ex_ctrl_t      r_ctrl;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_store;

  logic          w_ex_fwd;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;
  logic          w_stall;
  logic          w_bubble;
  ex_ctrl_t      w_cap_ctrl;
  logic [DW-1:0] w_cap_a;
  logic [DW-1:0] w_cap_b;

  // A load in EX has no result yet; it is resolved by the stall instead.
  assign w_ex_fwd = r_ctrl.valid & r_ctrl.wreg & ~r_ctrl.m2reg;

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .i_idx     (d_rs),
    .i_rf      (d_qa),
    .i_ex_fwd  (w_ex_fwd),
    .i_ex_rn   (r_ctrl.rn),
    .i_ex_s    (ex_alu_s),
    .i_m_wreg  (m_wreg),
    .i_m_m2reg (m_m2reg),
    .i_m_rn    (m_rn),
    .i_m_alu   (m_alu),
    .i_m_mo    (m_mo),
    .o_val     (w_fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .i_idx     (d_rt),
    .i_rf      (d_qb),
    .i_ex_fwd  (w_ex_fwd),
    .i_ex_rn   (r_ctrl.rn),
    .i_ex_s    (ex_alu_s),
    .i_m_wreg  (m_wreg),
    .i_m_m2reg (m_m2reg),
    .i_m_rn    (m_rn),
    .i_m_alu   (m_alu),
    .i_m_mo    (m_mo),
    .o_val     (w_fwd_rt)
  );

  // Load-use: decode reads the register a load in EX is about to produce.
  assign w_stall = d_valid & r_ctrl.valid & r_ctrl.wreg & r_ctrl.m2reg &
                   ((d_rs_used & idx_match(d_rs, r_ctrl.rn)) |
                    (d_rt_used & idx_match(d_rt, r_ctrl.rn)));
  assign stall_o  = w_stall;
  assign w_bubble = d_flush | w_stall | ~d_valid;

  // Operand selection and control word for a captured instruction.
  always_comb begin
    w_cap_ctrl       = EX_BUBBLE;
    w_cap_ctrl.valid = 1'b1;
    w_cap_ctrl.wreg  = d_wreg;
    w_cap_ctrl.m2reg = d_m2reg;
    w_cap_ctrl.wmem  = d_wmem;
    w_cap_ctrl.aluc  = d_aluc;
    w_cap_ctrl.rn    = d_rn;
    if (d_shift) begin
      w_cap_a = {{(DW-5){1'b0}}, d_sa};
    end else begin
      w_cap_a = w_fwd_rs;
    end
    if (d_aluimm) begin
      w_cap_b = d_imm;
    end else begin
      w_cap_b = w_fwd_rt;
    end
  end

  // EX register: reset, hold, bubble, or capture, in that priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl  <= EX_BUBBLE;
      r_a     <= '0;
      r_b     <= '0;
      r_store <= '0;
    end else if (ex_hold) begin
      r_ctrl  <= r_ctrl;
      r_a     <= r_a;
      r_b     <= r_b;
      r_store <= r_store;
    end else if (w_bubble) begin
      r_ctrl  <= EX_BUBBLE;
      r_a     <= '0;
      r_b     <= '0;
      r_store <= '0;
    end else begin
      r_ctrl  <= w_cap_ctrl;
      r_a     <= w_cap_a;
      r_b     <= w_cap_b;
      r_store <= w_fwd_rt;
    end
  end

  assign e_valid = r_ctrl.valid;
  assign e_wreg  = r_ctrl.wreg;
  assign e_m2reg = r_ctrl.m2reg;
  assign e_wmem  = r_ctrl.wmem;
  assign e_aluc  = r_ctrl.aluc;
  assign e_rn    = r_ctrl.rn;
  assign e_a     = r_a;
  assign e_b     = r_b;
  assign e_store = r_store;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table of instruction
// sequences followed by randomized cycles against a reference model.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset, d_valid, d_rs_used, d_rt_used, d_aluimm, d_shift;
  logic        d_wreg, d_m2reg, d_wmem, d_flush, ex_hold, m_wreg, m_m2reg;
  logic [31:0] d_qa, d_qb, d_imm, ex_alu_s, m_alu, m_mo;
  logic [4:0]  d_sa, d_rs, d_rt, d_rn, m_rn;
  logic [3:0]  d_aluc;
  logic        e_valid, e_wreg, e_m2reg, e_wmem, stall_o;
  logic [31:0] e_a, e_b, e_store;
  logic [3:0]  e_aluc;
  logic [4:0]  e_rn;

  always #5 clock = ~clock;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_qa(d_qa), .d_qb(d_qb),
    .d_imm(d_imm), .d_sa(d_sa), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .d_rn(d_rn),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift),
    .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_flush(d_flush),
    .ex_hold(ex_hold), .ex_alu_s(ex_alu_s), .m_rn(m_rn), .m_wreg(m_wreg),
    .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mo(m_mo), .e_valid(e_valid),
    .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_store(e_store), .e_rn(e_rn),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .stall_o(stall_o)
  );

  typedef struct {
    logic        rst, valid, flush, hold;
    logic [31:0] qa, qb, imm, ex_s, m_alu, m_mo;
    logic [4:0]  sa, rs, rt, rn, m_rn;
    logic        rs_used, rt_used, aluimm, shift, wreg, m2reg, wmem;
    logic [3:0]  aluc;
    logic        m_wreg, m_m2reg;
    logic        chk_stall, x_stall, x_valid;
    logic [31:0] x_a, x_b;
    logic [3:0]  x_aluc;
  } vec_t;

  typedef struct {
    logic        valid, wreg, m2reg, wmem;
    logic [3:0]  aluc;
    logic [4:0]  rn;
    logic [31:0] a, b, store;
  } mdl_t;

  vec_t tbl[$];
  mdl_t mdl;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; d_valid = v.valid; d_flush = v.flush; ex_hold = v.hold;
    d_qa = v.qa; d_qb = v.qb; d_imm = v.imm; d_sa = v.sa;
    d_rs = v.rs; d_rt = v.rt; d_rn = v.rn;
    d_rs_used = v.rs_used; d_rt_used = v.rt_used;
    d_aluc = v.aluc; d_aluimm = v.aluimm; d_shift = v.shift;
    d_wreg = v.wreg; d_m2reg = v.m2reg; d_wmem = v.wmem;
    ex_alu_s = v.ex_s; m_rn = v.m_rn; m_wreg = v.m_wreg;
    m_m2reg = v.m_m2reg; m_alu = v.m_alu; m_mo = v.m_mo;
  endtask

  function automatic vec_t op(input logic [4:0] rs, input logic [4:0] rt,
                              input logic rsu, input logic rtu,
                              input logic [31:0] qa, input logic [31:0] qb,
                              input logic [4:0] rn, input logic [3:0] aluc,
                              input logic wreg, input logic m2reg);
    vec_t v = '{default: '0};
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.rs_used = rsu; v.rt_used = rtu;
    v.qa = qa; v.qb = qb; v.rn = rn; v.aluc = aluc; v.wreg = wreg;
    v.m2reg = m2reg; v.chk_stall = 1'b1; v.x_valid = 1'b1; v.x_aluc = aluc;
    return v;
  endfunction

  // Reference: newest writer of a nonzero register supplies the value.
  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] rf, input vec_t v);
    if (idx == 5'd0) return rf;
    if (mdl.valid && mdl.wreg && !mdl.m2reg && mdl.rn == idx) return v.ex_s;
    if (v.m_wreg && v.m_rn == idx) return v.m_m2reg ? v.m_mo : v.m_alu;
    return rf;
  endfunction

  function automatic logic ref_stall(input vec_t v);
    logic is_load = mdl.valid && mdl.wreg && mdl.m2reg && mdl.rn != 5'd0;
    return v.valid && is_load &&
           ((v.rs_used && v.rs == mdl.rn) || (v.rt_used && v.rt == mdl.rn));
  endfunction

  task automatic model_step(input vec_t v, input logic st);
    mdl_t        nx = '{default: '0};
    logic [31:0] fa = ref_fwd(v.rs, v.qa, v);
    logic [31:0] fb = ref_fwd(v.rt, v.qb, v);
    if (v.rst) begin
      mdl = nx;
    end else if (v.hold) begin
      mdl = mdl;
    end else if (v.flush || st || !v.valid) begin
      mdl = nx;
    end else begin
      nx.valid = 1'b1; nx.wreg = v.wreg; nx.m2reg = v.m2reg; nx.wmem = v.wmem;
      nx.aluc = v.aluc; nx.rn = v.rn;
      nx.a = v.shift ? {27'd0, v.sa} : fa;
      nx.b = v.aluimm ? v.imm : fb;
      nx.store = fb;
      mdl = nx;
    end
  endtask

  function automatic vec_t rnd_vec(input logic force_rst);
    vec_t v = '{default: '0};
    v.rst = force_rst || ($urandom_range(0, 99) < 3);
    v.hold = ($urandom_range(0, 99) < 15);
    v.flush = ($urandom_range(0, 99) < 10);
    v.valid = ($urandom_range(0, 99) < 85);
    v.qa = $urandom; v.qb = $urandom; v.imm = $urandom; v.ex_s = $urandom;
    v.m_alu = $urandom; v.m_mo = $urandom; v.sa = 5'($urandom);
    v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
    v.rn = 5'($urandom_range(0, 3)); v.m_rn = 5'($urandom_range(0, 3));
    v.rs_used = 1'($urandom); v.rt_used = 1'($urandom);
    v.aluimm = 1'($urandom); v.shift = 1'($urandom);
    v.wreg = 1'($urandom); v.m2reg = 1'($urandom); v.wmem = 1'($urandom);
    v.aluc = 4'($urandom); v.m_wreg = 1'($urandom); v.m_m2reg = 1'($urandom);
    return v;
  endfunction

  initial begin
    vec_t v;
    logic st;

    // Reset for two cycles with live-looking inputs.
    v = op(5'd1, 5'd2, 1'b1, 1'b1, $urandom, $urandom, 5'd3, 4'b1010, 1'b1, 1'b1);
    v.rst = 1'b1; v.chk_stall = 1'b0; v.x_valid = 1'b0; v.x_aluc = 4'd0;
    tbl.push_back(v);
    v.chk_stall = 1'b1; tbl.push_back(v);
    // add $3 then sub $4,$3,$5: EX forward.
    v = op(5'd1, 5'd2, 1'b1, 1'b1, 32'h1, 32'h2, 5'd3, 4'b0010, 1'b1, 1'b0);
    v.x_a = 32'h1; v.x_b = 32'h2; tbl.push_back(v);
    v = op(5'd3, 5'd5, 1'b1, 1'b1, 32'hBAD, 32'h3, 5'd4, 4'b0100, 1'b1, 1'b0);
    v.ex_s = 32'h10; v.x_a = 32'h10; v.x_b = 32'h3; tbl.push_back(v);
    // lw $2, then and $6,$2,$7: one stall cycle, then MEM load forward.
    v = op(5'd1, 5'd2, 1'b1, 1'b0, 32'h100, 32'h0, 5'd2, 4'b0010, 1'b1, 1'b1);
    v.aluimm = 1'b1; v.ex_s = 32'h20; v.x_a = 32'h100; v.x_b = 32'h0; tbl.push_back(v);
    v = op(5'd2, 5'd7, 1'b1, 1'b1, 32'h55, 32'h7, 5'd6, 4'b0001, 1'b1, 1'b0);
    v.ex_s = 32'h104; v.x_stall = 1'b1; v.x_valid = 1'b0; v.x_aluc = 4'd0;
    tbl.push_back(v);
    v.m_rn = 5'd2; v.m_wreg = 1'b1; v.m_m2reg = 1'b1; v.m_mo = 32'hDEADBEEF;
    v.m_alu = 32'h104; v.x_stall = 1'b0; v.x_valid = 1'b1; v.x_aluc = 4'b0001;
    v.x_a = 32'hDEADBEEF; v.x_b = 32'h7; tbl.push_back(v);
    // sll $9,$6,4 (rt forwarded from EX), lui $10,0x1234.
    v = op(5'd0, 5'd6, 1'b0, 1'b1, 32'h0, 32'h1, 5'd9, 4'b0011, 1'b1, 1'b0);
    v.shift = 1'b1; v.sa = 5'd4; v.ex_s = 32'hF0; v.x_a = 32'h4; v.x_b = 32'hF0;
    tbl.push_back(v);
    v = op(5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd10, 4'b0110, 1'b1, 1'b0);
    v.aluimm = 1'b1; v.imm = 32'h1234; v.x_a = 32'h0; v.x_b = 32'h1234; tbl.push_back(v);
    // $8 written in EX and MEM: EX value wins.
    v = op(5'd0, 5'd0, 1'b1, 1'b0, 32'h5, 32'h0, 5'd8, 4'b0010, 1'b1, 1'b0);
    v.aluimm = 1'b1; v.imm = 32'h3; v.x_a = 32'h5; v.x_b = 32'h3; tbl.push_back(v);
    v = op(5'd8, 5'd8, 1'b1, 1'b1, 32'h1, 32'h1, 5'd11, 4'b0101, 1'b1, 1'b0);
    v.ex_s = 32'h88; v.m_rn = 5'd8; v.m_wreg = 1'b1; v.m_alu = 32'h77;
    v.x_a = 32'h88; v.x_b = 32'h88; tbl.push_back(v);
    // Destination $0: no stall behind lw $0, no forward of $0.
    v = op(5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 4'b0010, 1'b1, 1'b1);
    v.aluimm = 1'b1; v.imm = 32'h4; v.ex_s = 32'h11; v.x_a = 32'h0; v.x_b = 32'h4;
    tbl.push_back(v);
    v = op(5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd0, 4'b0010, 1'b1, 1'b0);
    v.ex_s = 32'h99; tbl.push_back(v);
    v = op(5'd0, 5'd0, 1'b1, 1'b1, 32'h5A, 32'h3C, 5'd12, 4'b0111, 1'b1, 1'b0);
    v.ex_s = 32'h99; v.m_rn = 5'd0; v.m_wreg = 1'b1; v.m_alu = 32'h66;
    v.x_a = 32'h5A; v.x_b = 32'h3C; tbl.push_back(v);
    // Hold beats flush for three cycles, then flush alone gives a bubble.
    for (int i = 0; i < 3; i++) begin
      v = op(5'd1, 5'd2, 1'b1, 1'b1, $urandom, $urandom, 5'd13, 4'b1111, 1'b1, 1'b1);
      v.hold = 1'b1; v.flush = 1'b1; v.x_aluc = 4'b0111;
      v.x_a = 32'h5A; v.x_b = 32'h3C; tbl.push_back(v);
    end
    v = op(5'd1, 5'd2, 1'b1, 1'b1, 32'h1, 32'h2, 5'd13, 4'b1111, 1'b1, 1'b0);
    v.flush = 1'b1; v.x_valid = 1'b0; v.x_aluc = 4'd0; tbl.push_back(v);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clock);
      if (tbl[i].chk_stall) chk($sformatf("tbl%0d stall_o", i), {31'd0, stall_o}, {31'd0, tbl[i].x_stall});
      @(posedge clock); #1;
      chk($sformatf("tbl%0d e_valid", i), {31'd0, e_valid}, {31'd0, tbl[i].x_valid});
      chk($sformatf("tbl%0d e_a", i), e_a, tbl[i].x_a);
      chk($sformatf("tbl%0d e_b", i), e_b, tbl[i].x_b);
      chk($sformatf("tbl%0d e_aluc", i), {28'd0, e_aluc}, {28'd0, tbl[i].x_aluc});
    end

    // Randomized phase; last table entry left EX as a bubble.
    mdl = '{default: '0};
    for (int i = 0; i < 600; i++) begin
      v = rnd_vec(i == 0);
      drive(v);
      @(negedge clock);
      st = ref_stall(v);
      chk("rnd stall_o", {31'd0, stall_o}, {31'd0, st});
      model_step(v, st);
      @(posedge clock); #1;
      chk("rnd e_valid", {31'd0, e_valid}, {31'd0, mdl.valid});
      chk("rnd e_a", e_a, mdl.a);
      chk("rnd e_b", e_b, mdl.b);
      chk("rnd e_store", e_store, mdl.store);
      chk("rnd e_aluc", {28'd0, e_aluc}, {28'd0, mdl.aluc});
      chk("rnd e_rn", {27'd0, e_rn}, {27'd0, mdl.rn});
      chk("rnd e_wreg", {31'd0, e_wreg}, {31'd0, mdl.wreg});
      chk("rnd e_m2reg", {31'd0, e_m2reg}, {31'd0, mdl.m2reg});
      chk("rnd e_wmem", {31'd0, e_wmem}, {31'd0, mdl.wmem});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand selector that sits directly upstream of the ALU. Captures one decoded instruction per cycle, resolves RAW hazards by forwarding from the EX and MEM stages, detects load-use hazards and inserts a bubble, and presents registered `a`, `b` and `aluc` to the ALU. Also carries the forwarded store data and the write-back controls into EX.

## Interface
Parameters:
- `DW`, 32: datapath width.
- `RW`, 5: register index width.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `d_valid`  in  1  decode slot holds a real instruction.
- `d_qa`, `d_qb`  in  DW  register-file reads for rs and rt.
- `d_imm`  in  DW  extended immediate.
- `d_sa`  in  5  shift amount.
- `d_rs`, `d_rt`  in  RW  source indices.
- `d_rs_used`, `d_rt_used`  in  1  the instruction actually reads rs or rt.
- `d_rn`  in  RW  destination index.
- `d_aluc`  in  4  ALU opcode.
- `d_aluimm`, `d_shift`, `d_wreg`, `d_m2reg`, `d_wmem`  in  1  decode controls.
- `d_flush`  in  1  squash the decode-slot instruction.
- `ex_hold`  in  1  downstream stall; freeze the EX register.
- `ex_alu_s`  in  DW  current ALU result (`s`) for the instruction in EX.
- `m_rn`  in  RW  MEM-stage destination.
- `m_wreg`, `m_m2reg`  in  1  MEM-stage controls.
- `m_alu`, `m_mo`  in  DW  MEM-stage ALU result and load data.
- `e_valid`  out  1  EX holds a real instruction.
- `e_a`, `e_b`  out  DW  ALU operands.
- `e_aluc`  out  4  ALU opcode.
- `e_store`  out  DW  forwarded rt for stores.
- `e_rn`  out  RW  EX-stage destination.
- `e_wreg`, `e_m2reg`, `e_wmem`  out  1  EX-stage controls.
- `stall_o`  out  1  combinational load-use stall request to PC/IF/ID.

## Operation
- Forwarding is applied separately to rs and rt. Priority for source `x`:
  - EX first: `e_valid & e_wreg & ~e_m2reg & e_rn==x & x!=0` selects `ex_alu_s`.
  - MEM next: `m_wreg & m_rn==x & x!=0` selects `m_mo` if `m_m2reg`, otherwise `m_alu`.
  - Otherwise the register-file value is used.
- The register file writes through, so WB results need no forwarding.
- Operand mux:
  - `a` is `{27'b0,d_sa}` when `d_shift`, otherwise forwarded rs.
  - `b` is `d_imm` when `d_aluimm`, otherwise forwarded rt.
  - `e_store` is always forwarded rt.
- Load-use detection: `stall_o = d_valid & e_valid & e_wreg & e_m2reg & e_rn!=0 & ((d_rs_used & d_rs==e_rn) | (d_rt_used & d_rt==e_rn))`.
- Index 0 never forwards and never stalls.
- Bubble: every output register is 0, including `e_valid`, `e_wreg`, `e_wmem` and `e_aluc`.

## Timing
- Single register stage. Decode values sampled at edge N appear on the `e_*` outputs after edge N.
- `stall_o` is combinational in the same cycle and is never registered.
- Per-edge priority:
  1. `reset`: all outputs 0.
  2. `ex_hold`: all `e_*` hold their values; `stall_o` is still evaluated.
  3. `d_flush`, `stall_o` or `~d_valid`: load a bubble.
  4. Otherwise: capture the decode instruction.
- The upstream stages freeze while `stall_o` is high. The stall lasts exactly one cycle, because the bubble clears `e_m2reg`; the load then sits in MEM and is forwarded from `m_mo`.
- While `ex_hold` is high, forwarding still uses the live `ex_alu_s` and MEM inputs.
- Reset asserted mid-stream clears EX within one edge. `stall_o` reads 0 in the cycle after reset.

## Structure
- Shared package `pipe_pkg`:
  - width constants `DW` and `RW`;
  - a packed `ex_ctrl_t` holding {valid, wreg, m2reg, wmem, aluc, rn};
  - the `EX_BUBBLE` constant.
- One sub-module, `fwd_mux`, instantiated twice (rs and rt). It takes an index plus the EX/MEM taps and the register-file value, and returns the forwarded value.
- Hazard logic and registers live in the top level.

## Test plan
- **Reset:** hold `reset` for 2 cycles with random inputs → all outputs 0 and `stall_o=0`.
- **EX forward:** `add $3,..` in EX with `ex_alu_s=0x10`, then `sub $4,$3,$5` with `d_qb=0x3` → `e_a=0x10`, `e_b=0x3`, `e_aluc=4'b0100`.
- **Load-use:** `lw $2` in EX, then `and $6,$2,$7` in decode → `stall_o=1` for one cycle and a bubble in EX. Next cycle, with `m_m2reg=1` and `m_mo=0xDEADBEEF`, `e_a=0xDEADBEEF` and `stall_o=0`.
- **Shift and immediate:** `sll` with `d_sa=4` → `e_a=0x4`, `e_b=` forwarded rt. `lui` with `d_imm=0x1234` → `e_b=0x1234`.
- **Precedence:** EX and MEM both write `$8` → the EX value wins. Destination `$0` with `e_rn=0` → no forward and no stall.
- **Hold vs flush:** `ex_hold=1` with `d_flush=1` for 3 cycles → `e_*` unchanged throughout. Release with `d_flush=1` → bubble (`e_valid=0`).
